// File: rtl/no_estimator_sched_if.sv
// Bundles the requester, estimator and result signals of the scheduler.
// The scheduler sits on the slave modport; the environment drives the master side.
interface no_estimator_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 128,
   parameter int RES_W   = 48,
   parameter int ID_W    = $clog2(NUM_REQ)
) ();
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      est_valid;
   logic [DATA_W-1:0]         est_data;
   logic                      est_out_valid;
   logic [RES_W-1:0]          est_out_data;
   logic                      est_out_ready;
   logic                      res_valid;
   logic [RES_W-1:0]          res_data;
   logic [ID_W-1:0]           res_id;
   logic                      res_ready;

   modport slave (
      input  req_valid, req_data, est_out_valid, est_out_data, res_ready,
      output req_ready, est_valid, est_data, est_out_ready, res_valid, res_data, res_id
   );

   modport master (
      output req_valid, req_data, est_out_valid, est_out_data, res_ready,
      input  req_ready, est_valid, est_data, est_out_ready, res_valid, res_data, res_id
   );
endinterface

// File: rtl/no_estimator_sched.sv
// Round-robin frame scheduler in front of a shared, reset-less estimator.
// After every reset the estimator's free-running beat counter is re-aligned
// with zero beats before any requester is granted.
//
//  state  | meaning
//  FLUSH  | drain stale estimator results, no beats, EST_LAT+2 cycles
//  SYNC_A | zero beats until a frame completes; estimator counter lands on EST_LAT
//  SYNC_B | BEATS-EST_LAT more zero beats to bring the counter back to 0
//  SYNC_C | drop the alignment result; estimator is now frame-aligned
//  IDLE   | round-robin search from rr_ptr for a valid requester
//  STREAM | forward exactly BEATS beats of the granted requester
//  WAIT   | wait for the estimator result, latch it with the grant id
//  RESP   | hold the result until the consumer takes it
module no_estimator_sched #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 128,
   parameter int BEATS   = 512,
   parameter int RES_W   = 48,
   parameter int EST_LAT = 6,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   no_estimator_sched_if.slave   sched_if
);
   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(EST_LAT + 1);
   localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(BEATS - EST_LAT - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      FLUSH, SYNC_A, SYNC_B, SYNC_C, IDLE, STREAM, WAIT, RESP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]   gnt_q, gnt_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              est_valid_q, est_valid_d;
   logic [DATA_W-1:0] est_data_q, est_data_d;
   logic              res_valid_q, res_valid_d;
   logic [RES_W-1:0]  res_data_q, res_data_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;

   logic              out_ready;
   logic              pick_ok;
   logic [ID_W-1:0]   pick;
   logic              xfer;
   logic [DATA_W-1:0] gnt_data;

   assign gnt_data = sched_if.req_data[int'(gnt_q)*DATA_W +: DATA_W];
   assign xfer     = (state_q == STREAM) && sched_if.req_valid[gnt_q];

   assign sched_if.req_ready     = (state_q == STREAM) ? (NUM_REQ'(1) << gnt_q) : '0;
   // FLUSH is the reset state, so keep est_out_ready low while rst is held.
   assign sched_if.est_out_ready = out_ready & ~rst;
   assign sched_if.est_valid     = est_valid_q;
   assign sched_if.est_data      = est_data_q;
   assign sched_if.res_valid     = res_valid_q;
   assign sched_if.res_data      = res_data_q;
   assign sched_if.res_id        = res_id_q;

   // Round-robin search: first valid requester at or above rr_ptr, with wrap.
   always_comb begin
      pick_ok = 1'b0;
      pick    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!pick_ok && sched_if.req_valid[idx]) begin
            pick_ok = 1'b1;
            pick    = ID_W'(idx);
         end
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      beat_cnt_d  = beat_cnt_q;
      gnt_d       = gnt_q;
      rr_ptr_d    = rr_ptr_q;
      est_valid_d = 1'b0;
      est_data_d  = est_data_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      out_ready   = 1'b0;
      case (state_q)
         FLUSH: begin
            out_ready = 1'b1;
            if (tmr_q == '0) state_d = SYNC_A;
            else             tmr_d   = tmr_q - 1'b1;
         end
         SYNC_A: begin
            est_valid_d = 1'b1;
            est_data_d  = '0;
            if (sched_if.est_out_valid) begin
               out_ready   = 1'b1;
               est_valid_d = 1'b0;
               tmr_d       = SYNC_LOAD;
               state_d     = SYNC_B;
            end
         end
         SYNC_B: begin
            est_valid_d = 1'b1;
            est_data_d  = '0;
            if (tmr_q == '0) state_d = SYNC_C;
            else             tmr_d   = tmr_q - 1'b1;
         end
         SYNC_C: begin
            if (sched_if.est_out_valid) begin
               out_ready = 1'b1;
               state_d   = IDLE;
            end
         end
         IDLE: begin
            if (pick_ok) begin
               gnt_d      = pick;
               beat_cnt_d = '0;
               state_d    = STREAM;
            end
         end
         STREAM: begin
            if (xfer) begin
               est_valid_d = 1'b1;
               est_data_d  = gnt_data;
               beat_cnt_d  = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) state_d = WAIT;
            end
         end
         WAIT: begin
            if (sched_if.est_out_valid) begin
               out_ready   = 1'b1;
               res_valid_d = 1'b1;
               res_data_d  = sched_if.est_out_data;
               res_id_d    = gnt_q;
               rr_ptr_d    = ID_W'((int'(gnt_q) + 1) % NUM_REQ);
               state_d     = RESP;
            end
         end
         RESP: begin
            if (sched_if.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = FLUSH;
      endcase
   end

   // State and output registers; reset aborts any frame and restarts alignment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FLUSH;
         tmr_q       <= FLUSH_LOAD;
         beat_cnt_q  <= '0;
         gnt_q       <= '0;
         rr_ptr_q    <= '0;
         est_valid_q <= 1'b0;
         est_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         beat_cnt_q  <= beat_cnt_d;
         gnt_q       <= gnt_d;
         rr_ptr_q    <= rr_ptr_d;
         est_valid_q <= est_valid_d;
         est_data_q  <= est_data_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
      end
   end
endmodule

// File: tb/tb_no_estimator_sched.sv
// Bench for no_estimator_sched with a behavioural reset-less estimator.
module tb_no_estimator_sched;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 128;
   localparam int BEATS   = 512;
   localparam int RES_W   = 48;
   localparam int EST_LAT = 6;
   localparam int ID_W    = 2;
   localparam int ALIGN_LIMIT = 2*BEATS + 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   no_estimator_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .ID_W(ID_W)) bus ();

   no_estimator_sched #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BEATS(BEATS), .RES_W(RES_W),
      .EST_LAT(EST_LAT), .ID_W(ID_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sched_if(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- estimator model: no reset, counter free-runs modulo BEATS
   int unsigned       m_cnt  = 37;
   logic [31:0]       m_sum  = 32'h0;
   logic [15:0]       m_zc   = 16'h0;
   logic              m_ov   = 1'b1;
   logic [RES_W-1:0]  m_od   = 48'hDEAD_BEEF_0BAD;
   logic [RES_W-1:0]  m_pend = '0;
   int                m_dly  = -1;
   logic [47:0]       cb;

   function automatic logic [47:0] beat_contrib(input logic [DATA_W-1:0] d);
      logic [31:0] s;
      logic [15:0] z;
      logic [3:0]  v;
      s = '0;
      z = '0;
      for (int n = 0; n < DATA_W/4; n++) begin
         v = d[n*4 +: 4];
         s = s + (32'd1 << (5'd16 - 5'(v)));
         if (v == 4'h0) z = z + 16'd1;
      end
      return {s, z};
   endfunction

   always_comb cb = beat_contrib(bus.est_data);

   assign bus.est_out_valid = m_ov;
   assign bus.est_out_data  = m_od;

   always @(posedge clk) begin
      if (m_ov && bus.est_out_ready) m_ov <= 1'b0;
      if (m_dly == 0) begin
         m_ov  <= 1'b1;
         m_od  <= m_pend;
         m_dly <= -1;
      end else if (m_dly > 0) begin
         m_dly <= m_dly - 1;
      end
      if (bus.est_valid) begin
         if (m_cnt == BEATS-1) begin
            m_pend <= {m_sum + cb[47:16], m_zc + cb[15:0]};
            m_dly  <= EST_LAT - 2;
            m_cnt  <= 0;
            m_sum  <= '0;
            m_zc   <= '0;
         end else begin
            m_cnt <= m_cnt + 1;
            m_sum <= m_sum + cb[47:16];
            m_zc  <= m_zc + cb[15:0];
         end
      end
   end

   // ---------------- requester sources
   logic [3:0] en  = '0;
   logic [3:0] bub = '0;
   logic [3:0] nib [NUM_REQ];

   initial begin
      bus.req_valid = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++)
            bus.req_valid[i] = en[i] & (~bub[i] | 1'($urandom_range(0, 1)));
      end
   end

   // ---------------- monitor
   logic              xfer;
   logic [DATA_W-1:0] xdata;
   logic              prev_xfer = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   int hs_cnt = 0, hs_base = 0, sb_beats = 0;
   int sync_ready_err = 0, sync_res_err = 0, fwd_err = 0, onehot_err = 0;
   int xfer_total = 0;
   logic aligned;

   always_comb begin
      xfer  = |(bus.req_valid & bus.req_ready);
      xdata = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (bus.req_ready[k]) xdata = bus.req_data[k*DATA_W +: DATA_W];
   end

   assign aligned = (hs_cnt >= hs_base + 2);

   always @(posedge clk) begin
      if (rst) begin
         hs_cnt    <= 0;
         hs_base   <= (m_ov || m_dly >= 0) ? 1 : 0;
         sb_beats  <= 0;
         prev_xfer <= 1'b0;
      end else begin
         if (bus.est_out_valid && bus.est_out_ready) hs_cnt <= hs_cnt + 1;
         if ($countones(bus.req_ready) > 1) onehot_err <= onehot_err + 1;
         if (!aligned) begin
            if (hs_cnt == hs_base + 1 && bus.est_valid) sb_beats <= sb_beats + 1;
            if (bus.req_ready != '0) sync_ready_err <= sync_ready_err + 1;
            if (bus.res_valid) sync_res_err <= sync_res_err + 1;
         end else begin
            if (bus.est_valid !== prev_xfer) fwd_err <= fwd_err + 1;
            else if (bus.est_valid && bus.est_data !== prev_data) fwd_err <= fwd_err + 1;
         end
         if (xfer) xfer_total <= xfer_total + 1;
         prev_xfer <= xfer;
         prev_data <= xdata;
      end
   end

   // ---------------- helpers
   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"},     64'(bus.req_ready), 64'h0);
      check({tag, "_est_valid"},     64'(bus.est_valid), 64'h0);
      check({tag, "_est_data"},      64'(bus.est_data[63:0] | bus.est_data[127:64]), 64'h0);
      check({tag, "_est_out_ready"}, 64'(bus.est_out_ready), 64'h0);
      check({tag, "_res_valid"},     64'(bus.res_valid), 64'h0);
      check({tag, "_res_data"},      64'(bus.res_data), 64'h0);
      check({tag, "_res_id"},        64'(bus.res_id), 64'h0);
   endtask

   task automatic wait_aligned(input string tag);
      int cyc;
      cyc = 0;
      while (!aligned && cyc < ALIGN_LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_align_in_time"}, 64'(aligned), 64'h1);
      check({tag, "_syncb_beats"},   64'(sb_beats), 64'(BEATS - EST_LAT));
      check({tag, "_est_counter"},   64'(m_cnt), 64'h0);
      check({tag, "_no_ready_sync"}, 64'(sync_ready_err), 64'h0);
      check({tag, "_no_res_sync"},   64'(sync_res_err), 64'h0);
   endtask

   task automatic wait_res(input string tag);
      int n;
      n = 0;
      while (!bus.res_valid && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_res_valid_seen"}, 64'(bus.res_valid), 64'h1);
   endtask

   task automatic pulse_ready();
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   // ---------------- frame table
   typedef struct {
      logic [3:0]       en;
      logic [3:0]       bub;
      int               hold;
      logic [ID_W-1:0]  id;
      logic [RES_W-1:0] data;
   } vec_t;

   vec_t tbl [7];

   initial begin
      bit pending;
      int base, n;

      // requester i sends a constant nibble; per-nibble weight is 2^(16-v)
      nib[0] = 4'h1;
      nib[1] = 4'hF;
      nib[2] = 4'h0;
      nib[3] = 4'h2;
      for (int i = 0; i < NUM_REQ; i++)
         bus.req_data[i*DATA_W +: DATA_W] = {32{nib[i]}};
      bus.res_ready = 1'b0;

      // all four contend: grants 0,1,2,3,0
      tbl[0] = '{4'hF, 4'h0, 0,   2'd0, {32'h2000_0000, 16'h0000}};
      tbl[1] = '{4'hF, 4'h0, 0,   2'd1, {32'h0000_8000, 16'h0000}};
      tbl[2] = '{4'hF, 4'h0, 0,   2'd2, {32'h4000_0000, 16'h4000}};
      tbl[3] = '{4'hF, 4'h0, 0,   2'd3, {32'h1000_0000, 16'h0000}};
      tbl[4] = '{4'hF, 4'h0, 0,   2'd0, {32'h2000_0000, 16'h0000}};
      // requester 2 alone, all-zero nibbles, consumer stalls 100 cycles
      tbl[5] = '{4'h4, 4'h0, 100, 2'd2, {32'h4000_0000, 16'h4000}};
      // requester 1 alone, all-0xF nibbles with random bubbles
      tbl[6] = '{4'h2, 4'h2, 0,   2'd1, {32'h0000_8000, 16'h0000}};

      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("por");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_aligned("por");

      pending = 1'b0;
      for (int i = 0; i < 7; i++) begin
         en  = tbl[i].en;
         bub = tbl[i].bub;
         if (pending) pulse_ready();
         wait_res($sformatf("vec%0d", i));
         check($sformatf("vec%0d_res_id", i),   64'(bus.res_id),   64'(tbl[i].id));
         check($sformatf("vec%0d_res_data", i), 64'(bus.res_data), 64'(tbl[i].data));
         for (int h = 0; h < tbl[i].hold; h++) begin
            @(negedge clk);
            check($sformatf("vec%0d_hold_data", i),  64'(bus.res_data),      64'(tbl[i].data));
            check($sformatf("vec%0d_hold_valid", i), 64'(bus.res_valid),     64'h1);
            check($sformatf("vec%0d_hold_ready", i), 64'(bus.req_ready),     64'h0);
            check($sformatf("vec%0d_hold_oready", i), 64'(bus.est_out_ready), 64'h0);
         end
         pending = 1'b1;
      end

      // abort a frame of requester 2 at beat 200, then rerun it
      en  = 4'h4;
      bub = 4'h0;
      pulse_ready();
      base = xfer_total;
      n = 0;
      while ((xfer_total - base) < 200 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("abort_beat200_reached", 64'(xfer_total - base), 64'd200);
      rst = 1'b1;
      #1;
      check_reset_vals("abort");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_aligned("abort");
      wait_res("rerun");
      check("rerun_res_id",   64'(bus.res_id),   64'd2);
      check("rerun_res_data", 64'(bus.res_data), 64'({32'h4000_0000, 16'h4000}));
      en = 4'h0;
      pulse_ready();
      repeat (20) @(negedge clk);

      check("forwarding_clean", 64'(fwd_err),    64'h0);
      check("req_ready_onehot", 64'(onehot_err), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
